csel_addsub_pipe: RTL and testbench

- Parametrised, 2-stage pipelined carry-select adder/subtractor with a valid/ready handshake.
- Successor to the fixed 4-bit carry-select subtractor: adds generic width, an add/sub/absolute-difference mode, status flags and backpressure.
- Sits between operand sources and the datapath consumers; one operation accepted per cycle at full throughput.

---
 rtl/addsub_pkg.sv | 39 +++
 rtl/csel_block.sv | 36 +++
 rtl/csel_addsub_pipe.sv | 271 +++++++++++++++++++++++++++
 tb/tb_csel_addsub_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
//
// Purpose : shared definitions for the pipelined carry-select adder/subtractor
//           (csel_addsub_pipe) and its carry-select building block.
//
// Contents:
//   MODE_ADD / MODE_SUB / MODE_ABSDIFF - operation encodings on the 2-bit mode
//                                        port (2'b11 decodes as subtract)
//   stage1Ctrl_t                       - width-independent control payload
//                                        carried from stage 1 to stage 2
//   cfgOk()                            - geometry check used at elaboration
// ---------------------------------------------------------------------------
package addsub_pkg;

  localparam logic [1:0] MODE_ADD     = 2'b00;
  localparam logic [1:0] MODE_SUB     = 2'b01;
  localparam logic [1:0] MODE_ABSDIFF = 2'b10;

  // Control half of the stage-1 payload. The wide sum candidates live in
  // separate registers because their width follows the WIDTH parameter.
  //   mode - operation of this beat
  //   aMsb - sign bit of operand A
  //   bMsb - sign bit of the effective (possibly inverted) operand B
  //   cLo  - carry out of the low half, selects the high-half candidate
  typedef struct packed {
    logic [1:0] mode;
    logic       aMsb;
    logic       bMsb;
    logic       cLo;
  } stage1Ctrl_t;

  // The datapath splits the operands into whole BLOCK-wide slices and needs
  // at least one slice in each half.
  function automatic bit cfgOk(input int width, input int block);
    return (block > 0) && ((width % block) == 0) && (width >= 2 * block);
  endfunction

endpackage

// File: rtl/csel_block.sv
// ---------------------------------------------------------------------------
// csel_block
//
// Purpose : one carry-select slice. Adds two BLOCK-bit values twice, once
//           assuming carry-in 0 and once assuming carry-in 1, so the real
//           carry only has to pick a result instead of rippling through.
//
// Ports:
//   a_i, b_i    in  [BLOCK-1:0]  slice operands
//   sum0_o      out [BLOCK-1:0]  sum with carry-in 0
//   c0_o        out              carry-out with carry-in 0
//   sum1_o      out [BLOCK-1:0]  sum with carry-in 1
//   c1_o        out              carry-out with carry-in 1
// ---------------------------------------------------------------------------
module csel_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  output logic [BLOCK-1:0] sum0_o,
  output logic             c0_o,
  output logic [BLOCK-1:0] sum1_o,
  output logic             c1_o
);

  logic [BLOCK:0] aExt;
  logic [BLOCK:0] bExt;

  assign aExt = {1'b0, a_i};
  assign bExt = {1'b0, b_i};

  // Both candidates are produced unconditionally; the caller chooses.
  assign {c0_o, sum0_o} = aExt + bExt;
  assign {c1_o, sum1_o} = aExt + bExt + (BLOCK+1)'(1);

endmodule

// File: rtl/csel_addsub_pipe.sv
// ---------------------------------------------------------------------------
// csel_addsub_pipe
//
// Purpose : two-stage pipelined carry-select adder / subtractor / absolute
//           difference unit with a valid/ready handshake on both sides.
//           Stage 1 resolves the low half and both high-half candidates,
//           stage 2 selects the high half and forms result and flags.
//
// Parameters:
//   WIDTH - operand/result width (multiple of BLOCK, at least 2*BLOCK)
//   BLOCK - carry-select slice width
//
// Ports:
//   clk        in               rising-edge clock
//   rst        in               synchronous active-high reset
//   in_valid   in               operand beat valid
//   in_ready   out              beat can be accepted this cycle
//   a, b       in  [WIDTH-1:0]  operands
//   c_in       in               ADD carry-in / SUB borrow-in / ignored ABSDIFF
//   mode       in  [1:0]        00 ADD, 01 SUB, 10 ABSDIFF, 11 SUB
//   out_valid  out              result beat valid
//   out_ready  in               consumer takes the result
//   result     out [WIDTH-1:0]  sum, difference or magnitude
//   c_out      out              ADD carry, SUB no-borrow, ABSDIFF 0
//   ovf        out              signed overflow (ADD/SUB), 0 for ABSDIFF
//   neg        out              ADD/SUB result MSB, ABSDIFF a < b
//
// Build option:
//   CSEL_ADDSUB_SAT_EN - when defined, ADD/SUB results that overflow clamp to
//                        the signed max/min matching the operand sign.
// ---------------------------------------------------------------------------
module csel_addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             neg
);

  localparam int NB     = WIDTH / BLOCK;
  localparam int NLO    = NB / 2;
  localparam int NHI    = NB - NLO;
  localparam int LOW_W  = NLO * BLOCK;
  localparam int HIGH_W = WIDTH - LOW_W;

  if (!cfgOk(WIDTH, BLOCK)) begin : gBadCfg
    $error("csel_addsub_pipe: WIDTH must be a multiple of BLOCK and >= 2*BLOCK");
  end

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic v1_q;
  logic v2_q;
  logic adv1;
  logic adv2;

  // A stage may advance when it is empty or its successor is advancing, so
  // a full pipe with a ready consumer still takes a new beat every cycle.
  assign adv2     = ~v2_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;

  // ---------------------------------------------------------------------
  // Stage 1: operand conditioning
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] bEff;
  logic             cinEff;

  // Subtraction is a + ~b + ~borrow; absolute difference always starts as
  // a - b with no borrow and fixes the sign in stage 2.
  always_comb begin
    bEff   = b;
    cinEff = c_in;
    case (mode)
      MODE_ADD: begin
        bEff   = b;
        cinEff = c_in;
      end
      MODE_ABSDIFF: begin
        bEff   = ~b;
        cinEff = 1'b1;
      end
      default: begin
        bEff   = ~b;
        cinEff = ~c_in;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 1: low half, carry selected slice by slice with the real carry
  // ---------------------------------------------------------------------
  logic [NLO:0]     loCarry;
  logic [LOW_W-1:0] loSum;

  assign loCarry[0] = cinEff;

  for (genvar gi = 0; gi < NLO; gi++) begin : gLo
    logic [BLOCK-1:0] s0;
    logic [BLOCK-1:0] s1;
    logic             c0;
    logic             c1;

    csel_block #(.BLOCK(BLOCK)) uBlk (
      .a_i    (a[gi*BLOCK +: BLOCK]),
      .b_i    (bEff[gi*BLOCK +: BLOCK]),
      .sum0_o (s0),
      .c0_o   (c0),
      .sum1_o (s1),
      .c1_o   (c1)
    );

    assign loSum[gi*BLOCK +: BLOCK] = loCarry[gi] ? s1 : s0;
    assign loCarry[gi+1]            = loCarry[gi] ? c1 : c0;
  end

  // ---------------------------------------------------------------------
  // Stage 1: high half, two full candidates (half carry-in 0 and 1), each
  // chained through the slices by carry select
  // ---------------------------------------------------------------------
  logic [NHI:0]      hiCarry0;
  logic [NHI:0]      hiCarry1;
  logic [HIGH_W-1:0] hiSum0;
  logic [HIGH_W-1:0] hiSum1;

  assign hiCarry0[0] = 1'b0;
  assign hiCarry1[0] = 1'b1;

  for (genvar gj = 0; gj < NHI; gj++) begin : gHi
    logic [BLOCK-1:0] s0;
    logic [BLOCK-1:0] s1;
    logic             c0;
    logic             c1;

    csel_block #(.BLOCK(BLOCK)) uBlk (
      .a_i    (a[LOW_W + gj*BLOCK +: BLOCK]),
      .b_i    (bEff[LOW_W + gj*BLOCK +: BLOCK]),
      .sum0_o (s0),
      .c0_o   (c0),
      .sum1_o (s1),
      .c1_o   (c1)
    );

    assign hiSum0[gj*BLOCK +: BLOCK] = hiCarry0[gj] ? s1 : s0;
    assign hiCarry0[gj+1]            = hiCarry0[gj] ? c1 : c0;
    assign hiSum1[gj*BLOCK +: BLOCK] = hiCarry1[gj] ? s1 : s0;
    assign hiCarry1[gj+1]            = hiCarry1[gj] ? c1 : c0;
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  stage1Ctrl_t       ctrl1_d;
  stage1Ctrl_t       ctrl1_q;
  logic [LOW_W-1:0]  loSum_q;
  logic [HIGH_W-1:0] hiSum0_q;
  logic [HIGH_W-1:0] hiSum1_q;
  logic              hiC0_q;
  logic              hiC1_q;

  assign ctrl1_d.mode = mode;
  assign ctrl1_d.aMsb = a[WIDTH-1];
  assign ctrl1_d.bMsb = bEff[WIDTH-1];
  assign ctrl1_d.cLo  = loCarry[NLO];

  // Stage 1 captures a new beat (or a bubble) whenever it may advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      ctrl1_q  <= '0;
      loSum_q  <= '0;
      hiSum0_q <= '0;
      hiSum1_q <= '0;
      hiC0_q   <= 1'b0;
      hiC1_q   <= 1'b0;
    end else if (adv1) begin
      v1_q     <= in_valid;
      ctrl1_q  <= ctrl1_d;
      loSum_q  <= loSum;
      hiSum0_q <= hiSum0;
      hiSum1_q <= hiSum1;
      hiC0_q   <= hiCarry0[NHI];
      hiC1_q   <= hiCarry1[NHI];
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: final select, flags and absolute-difference correction
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] rRaw;
  logic             co;
  logic             ovfRaw;
  logic [WIDTH-1:0] result_d;
  logic             cOut_d;
  logic             ovf_d;
  logic             neg_d;

  // For ABSDIFF a missing carry means a < b, so the raw difference is
  // negative and is negated to give the magnitude. With the saturation
  // option, overflowing ADD/SUB results clamp toward the operand sign.
  always_comb begin
    rRaw     = {(ctrl1_q.cLo ? hiSum1_q : hiSum0_q), loSum_q};
    co       = ctrl1_q.cLo ? hiC1_q : hiC0_q;
    ovfRaw   = (ctrl1_q.aMsb == ctrl1_q.bMsb) && (rRaw[WIDTH-1] != ctrl1_q.aMsb);
    result_d = rRaw;
    cOut_d   = co;
    ovf_d    = ovfRaw;
    neg_d    = rRaw[WIDTH-1];
    if (ctrl1_q.mode == MODE_ABSDIFF) begin
      ovf_d    = 1'b0;
      cOut_d   = 1'b0;
      neg_d    = ~co;
      result_d = co ? rRaw : (~rRaw + WIDTH'(1));
    end
`ifdef CSEL_ADDSUB_SAT_EN
    else if (ovfRaw) begin
      result_d = ctrl1_q.aMsb ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
      neg_d    = ctrl1_q.aMsb;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Stage 2 registers (the visible outputs)
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] result_q;
  logic             cOut_q;
  logic             ovf_q;
  logic             neg_q;

  // Output registers only move when the consumer has taken the current beat
  // or there is none, which keeps a stalled result stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q     <= 1'b0;
      result_q <= '0;
      cOut_q   <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else if (adv2) begin
      v2_q     <= v1_q;
      result_q <= result_d;
      cOut_q   <= cOut_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
    end
  end

  assign out_valid = v2_q;
  assign result    = result_q;
  assign c_out     = cOut_q;
  assign ovf       = ovf_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_csel_addsub_pipe
//
// Purpose : directed, table-driven bench for csel_addsub_pipe (WIDTH=16,
//           BLOCK=4). Expected values are hand-computed; results that depend
//           on CSEL_ADDSUB_SAT_EN follow the same macro.
// ---------------------------------------------------------------------------
module tb_csel_addsub_pipe;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ABS = 2'b10;
  localparam logic [1:0] M_11  = 2'b11;

`ifdef CSEL_ADDSUB_SAT_EN
  localparam logic [15:0] OVF_ADD_RES = 16'h7FFF;
  localparam logic [15:0] OVF_SUB_RES = 16'h8000;
`else
  localparam logic [15:0] OVF_ADD_RES = 16'h8000;
  localparam logic [15:0] OVF_SUB_RES = 16'h7FFF;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        c_out;
  logic        ovf;
  logic        neg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] expRes;
    logic        expC;
    logic        expO;
    logic        expN;
    bit          chkN;
  } vec_t;

  vec_t vecs[15];

  csel_addsub_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .ovf       (ovf),
    .neg       (neg)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait somewhere never resolves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Result side of one beat: called once out_valid is due.
  task automatic checkOutput(input vec_t v);
    check({v.name, ".out_valid"}, 32'(out_valid), 32'd1);
    check({v.name, ".result"},    32'(result),    32'(v.expRes));
    check({v.name, ".c_out"},     32'(c_out),     32'(v.expC));
    check({v.name, ".ovf"},       32'(ovf),       32'(v.expO));
    if (v.chkN) check({v.name, ".neg"}, 32'(neg), 32'(v.expN));
  endtask

  // Single beat with no backpressure: accept, confirm out_valid is still
  // low one edge later, then check the result exactly two edges after
  // acceptance and let the consumer take it.
  task automatic applyStimulus(input vec_t v);
    out_ready = 1'b1;
    mode      = v.mode;
    a         = v.a;
    b         = v.b;
    c_in      = v.cin;
    in_valid  = 1'b1;
    #1;
    check({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
    nextCycle();
    in_valid = 1'b0;
    check({v.name, ".lat1"}, 32'(out_valid), 32'd0);
    nextCycle();
    checkOutput(v);
    nextCycle();
  endtask

  initial begin
    logic [15:0] expQ[$];
    logic [15:0] holdVal;
    bit          holdPend;
    bit          sawStall;
    int          sent;
    int          got;
    vec_t        v;

    vecs[0]  = '{"add_ff_1",    M_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{"sub_3_5",     M_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{"sub_5_3_bin", M_SUB, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{"abs_3_5",     M_ABS, 16'h0003, 16'h0005, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{"abs_5_3",     M_ABS, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{"abs_eq",      M_ABS, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{"add_ovf",     M_ADD, 16'h7FFF, 16'h0001, 1'b0, OVF_ADD_RES, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"sub_ovf",     M_SUB, 16'h8000, 16'h0001, 1'b0, OVF_SUB_RES, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"sub_zero_b",  M_SUB, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{"add_max",     M_ADD, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{"mode11",      M_11,  16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{"add_midcarry",M_ADD, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{"add_wrap0",   M_ADD, 16'h00FF, 16'hFF01, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{"abs_cin_ign", M_ABS, 16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{"abs_big_neg", M_ABS, 16'h0010, 16'h1234, 1'b0, 16'h1224, 1'b0, 1'b0, 1'b1, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    mode      = M_ADD;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.result",    32'(result),    32'd0);
    check("rst.c_out",     32'(c_out),     32'd0);
    check("rst.ovf",       32'(ovf),       32'd0);
    check("rst.neg",       32'(neg),       32'd0);

    // Table-driven single beats
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    // Six-beat stream with the consumer stalled in cycles 3..5
    sent     = 0;
    got      = 0;
    holdPend = 1'b0;
    sawStall = 1'b0;
    mode     = M_ADD;
    b        = 16'h0001;
    c_in     = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 6);
      a         = 16'(sent * 16'h0111 + 16'h0100);
      #1;
      if (holdPend) begin
        check("stream.hold", 32'(result), 32'(holdVal));
        holdPend = 1'b0;
      end
      if (!in_ready) sawStall = 1'b1;
      if (in_valid && in_ready) begin
        expQ.push_back(a + 16'h0001);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL stream.extra: got %0h expected no beat", result);
        end else begin
          check($sformatf("stream.beat%0d", got), 32'(result), 32'(expQ.pop_front()));
        end
        got++;
      end else if (out_valid) begin
        holdPend = 1'b1;
        holdVal  = result;
      end
      nextCycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream.delivered", 32'(got), 32'd6);
    check("stream.sent",      32'(sent), 32'd6);
    check("stream.stalled",   32'(sawStall), 32'd1);
    check("stream.leftover",  32'(expQ.size()), 32'd0);
    #1;
    check("stream.drained", 32'(out_valid), 32'd0);
    nextCycle();

    // Fill both stages under backpressure, then reset mid-flight
    out_ready = 1'b0;
    mode      = M_ADD;
    a         = 16'h1111;
    b         = 16'h2222;
    c_in      = 1'b0;
    in_valid  = 1'b1;
    nextCycle();
    a = 16'h3333;
    nextCycle();
    in_valid = 1'b0;
    check("full.out_valid", 32'(out_valid), 32'd1);
    check("full.in_ready",  32'(in_ready),  32'd0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready",  32'(in_ready),  32'd1);

    v = '{"post_rst", M_ADD, 16'h0040, 16'h0002, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(v);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post_rst.idle%0d", k), 32'(out_valid), 32'd0);
      nextCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
